// File: rtl/riscv_pkg.sv
// Shared types for the writeback/register-file slice: register index width
// and the writeback result-source encoding.
package riscv_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned INSTRET_W = 64;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

endpackage

// File: rtl/reg_file.sv
// Architectural register storage: two combinational read ports, one write
// port, synchronous active-low clear, x0 hardwired to zero.
module reg_file
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [REG_IDX_W-1:0] i_ra1,
    input  logic [REG_IDX_W-1:0] i_ra2,
    output logic [WIDTH-1:0]     o_rd1_c,
    output logic [WIDTH-1:0]     o_rd2_c
);

    logic [WIDTH-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 never reads the array, so a stray write there can never leak out
    assign o_rd1_c = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    assign o_rd2_c = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + register file: result select, write-first bypass to the
// decode read ports, retired-instruction counter and sticky bad-source flag.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int unsigned        WIDTH        = 32,
    parameter int unsigned        NREGS        = 32,
    // Value instret takes on reset; 0 for normal use
    parameter logic [INSTRET_W-1:0] INSTRET_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_write_w,
    input  logic [1:0]           result_src_w,
    input  logic [WIDTH-1:0]     alu_result_w,
    input  logic [WIDTH-1:0]     read_data_w,
    input  logic [WIDTH-1:0]     pc_plus4_w,
    input  logic [REG_IDX_W-1:0] rd_w,
    input  logic                 valid_w,
    input  logic [REG_IDX_W-1:0] a1_d,
    input  logic [REG_IDX_W-1:0] a2_d,
    output logic [WIDTH-1:0]     rd1_d,
    output logic [WIDTH-1:0]     rd2_d,
    output logic [WIDTH-1:0]     result_w,
    output logic [INSTRET_W-1:0] instret,
    output logic                 err_src
);

    logic [WIDTH-1:0]     w_result;
    logic                 w_src_rsvd;
    logic                 w_wr_en;
    logic [WIDTH-1:0]     w_rf_rd1;
    logic [WIDTH-1:0]     w_rf_rd2;
    logic [INSTRET_W-1:0] r_instret;
    logic                 r_err_src;

    // Result select
    always_comb begin
        w_result = '0;
        unique case (result_src_e'(result_src_w))
            RES_ALU:  w_result = alu_result_w;
            RES_MEM:  w_result = read_data_w;
            RES_PC4:  w_result = pc_plus4_w;
            default:  w_result = '0;
        endcase
    end

    assign w_src_rsvd = (result_src_e'(result_src_w) == RES_RSVD);
    assign w_wr_en    = rst && reg_write_w && (rd_w != '0) && !w_src_rsvd;

    reg_file #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (rd_w),
        .i_wdata (w_result),
        .i_ra1   (a1_d),
        .i_ra2   (a2_d),
        .o_rd1_c (w_rf_rd1),
        .o_rd2_c (w_rf_rd2)
    );

    // Write-first bypass; w_wr_en already excludes x0, reserved source and reset
    always_comb begin
        rd1_d = w_rf_rd1;
        rd2_d = w_rf_rd2;
        if (!rst) begin
            rd1_d = '0;
            rd2_d = '0;
        end else begin
            if (w_wr_en && (a1_d == rd_w)) rd1_d = w_result;
            if (w_wr_en && (a2_d == rd_w)) rd2_d = w_result;
        end
    end

    // Retire counter wraps silently; error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instret <= INSTRET_INIT;
            r_err_src <= 1'b0;
        end else begin
            if (valid_w) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
            if (reg_write_w && w_src_rsvd) begin
                r_err_src <= 1'b1;
            end
        end
    end

    assign result_w = w_result;
    assign instret  = r_instret;
    assign err_src  = r_err_src;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile: table of per-cycle stimulus with
// expected pre-edge outputs, plus sequences for sticky error, reset and wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        reg_write_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w;
    logic [31:0] read_data_w;
    logic [31:0] pc_plus4_w;
    logic [4:0]  rd_w;
    logic        valid_w;
    logic [4:0]  a1_d;
    logic [4:0]  a2_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [31:0] result_w;
    logic [63:0] instret;
    logic        err_src;

    logic        rst2;
    logic        valid2;
    logic [31:0] w_rd1_d;
    logic [31:0] w_rd2_d;
    logic [31:0] w_result_w;
    logic [63:0] w_instret;
    logic        w_err_src;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_w  (reg_write_w),
        .result_src_w (result_src_w),
        .alu_result_w (alu_result_w),
        .read_data_w  (read_data_w),
        .pc_plus4_w   (pc_plus4_w),
        .rd_w         (rd_w),
        .valid_w      (valid_w),
        .a1_d         (a1_d),
        .a2_d         (a2_d),
        .rd1_d        (rd1_d),
        .rd2_d        (rd2_d),
        .result_w     (result_w),
        .instret      (instret),
        .err_src      (err_src)
    );

    // Second instance with the counter preset near wrap
    wb_regfile #(.INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFE)) dut_wrap (
        .clk          (clk),
        .rst          (rst2),
        .reg_write_w  (reg_write_w),
        .result_src_w (result_src_w),
        .alu_result_w (alu_result_w),
        .read_data_w  (read_data_w),
        .pc_plus4_w   (pc_plus4_w),
        .rd_w         (rd_w),
        .valid_w      (valid2),
        .a1_d         (a1_d),
        .a2_d         (a2_d),
        .rd1_d        (w_rd1_d),
        .rd2_d        (w_rd2_d),
        .result_w     (w_result_w),
        .instret      (w_instret),
        .err_src      (w_err_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        valid;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_res;
        logic [63:0] e_inst;
        logic        e_err;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // rst we src alu mem pc4 rd valid a1 a2 | rd1 rd2 res inst err
        vecs[0] = '{1'b0, 1'b1, 2'd0, 32'h0000_AAAA, 32'h0, 32'h0, 5'd5, 1'b1, 5'd5, 5'd0,
                    32'h0, 32'h0, 32'h0000_AAAA, 64'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 5'd5, 5'd6,
                    32'h0000_1234, 32'h0, 32'h0000_1234, 64'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 32'h0000_9999, 32'h0, 32'h0, 5'd5, 1'b0, 5'd5, 5'd5,
                    32'h0000_1234, 32'h0000_1234, 32'h0000_9999, 64'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0, 5'd7, 1'b1, 5'd7, 5'd7,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 64'd1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0000_0080, 5'd8, 1'b1, 5'd7, 5'd8,
                    32'hDEAD_BEEF, 32'h0000_0080, 32'h0000_0080, 64'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 5'd8,
                    32'h0, 32'h0000_0080, 32'hFFFF_FFFF, 64'd3, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd0, 5'd5,
                    32'h0, 32'h0000_1234, 32'h0, 64'd3, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'd3, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055, 5'd3, 1'b1, 5'd3, 5'd5,
                    32'h0, 32'h0000_1234, 32'h0, 64'd4, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 5'd3, 5'd7,
                    32'h0, 32'hDEAD_BEEF, 32'h0, 64'd5, 1'b1};

        rst = 1'b0; reg_write_w = 1'b0; result_src_w = 2'd0;
        alu_result_w = '0; read_data_w = '0; pc_plus4_w = '0;
        rd_w = '0; valid_w = 1'b0; a1_d = '0; a2_d = '0;
        rst2 = 1'b0; valid2 = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            reg_write_w  = vecs[i].we;
            result_src_w = vecs[i].src;
            alu_result_w = vecs[i].alu;
            read_data_w  = vecs[i].mem;
            pc_plus4_w   = vecs[i].pc4;
            rd_w         = vecs[i].rd;
            valid_w      = vecs[i].valid;
            a1_d         = vecs[i].a1;
            a2_d         = vecs[i].a2;
            #1;
            chk($sformatf("v%0d rd1", i), 64'(rd1_d), 64'(vecs[i].e_rd1));
            chk($sformatf("v%0d rd2", i), 64'(rd2_d), 64'(vecs[i].e_rd2));
            chk($sformatf("v%0d result", i), 64'(result_w), 64'(vecs[i].e_res));
            chk($sformatf("v%0d instret", i), instret, vecs[i].e_inst);
            chk($sformatf("v%0d err_src", i), 64'(err_src), 64'(vecs[i].e_err));
        end

        // Sticky error held with x3 still zero over idle cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            reg_write_w = 1'b0; valid_w = 1'b0; result_src_w = 2'd0;
            a1_d = 5'd3; a2_d = 5'd0;
            #1;
            chk($sformatf("hold%0d err_src", k), 64'(err_src), 64'd1);
            chk($sformatf("hold%0d x3", k), 64'(rd1_d), 64'd0);
        end

        // Reset during a write of x9
        @(negedge clk);
        rst = 1'b0; reg_write_w = 1'b1; result_src_w = 2'd0;
        alu_result_w = 32'h0000_0055; rd_w = 5'd9; valid_w = 1'b1;
        a1_d = 5'd9; a2_d = 5'd5;
        #1;
        chk("rstcyc rd1", 64'(rd1_d), 64'd0);
        chk("rstcyc rd2", 64'(rd2_d), 64'd0);
        chk("rstcyc result", 64'(result_w), 64'h55);
        chk("rstcyc instret", instret, 64'd5);
        @(negedge clk);
        rst = 1'b1; reg_write_w = 1'b0; valid_w = 1'b0;
        #1;
        chk("postrst x9", 64'(rd1_d), 64'd0);
        chk("postrst x5", 64'(rd2_d), 64'd0);
        chk("postrst instret", instret, 64'd0);
        chk("postrst err_src", 64'(err_src), 64'd0);

        // Counter wrap on the preset instance
        @(negedge clk);
        rst2 = 1'b1; valid2 = 1'b0;
        #1;
        chk("wrap preset", w_instret, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        valid2 = 1'b1;
        @(posedge clk); #1;
        chk("wrap max", w_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap zero", w_instret, 64'd0);
        @(posedge clk); #1;
        chk("wrap one", w_instret, 64'd1);
        valid2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap idle", w_instret, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
